aesl_deadlock_group_monitor: RTL and testbench
==============================================

Name: aesl_deadlock_group_monitor

Overview:
- Parametrised, grouped deadlock monitor for the C/RTL co-simulation bench of yolo_conv_top and its successors.
- Watches per-channel AXIS block signals, per-channel instance idle signals and per-instance block signals, organised into NUM_GROUPS equal groups.
- Declares a deadlock only after the blocking condition has persisted for THRESH consecutive cycles; THRESH=1 gives single-registered-cycle detection.
- Adds sticky reporting, a first-event group/timestamp capture and per-group masking, none of which the fixed 4-channel monitor has.

Parameters:
NUM_AXIS, 4, total AXIS channels; must be a multiple of NUM_GROUPS
NUM_GROUPS, 2, number of channel groups; CH = NUM_AXIS/NUM_GROUPS channels per group
NUM_INST, 1, number of sub-instance block inputs
THRESH, 16, consecutive blocked cycles before block asserts; legal range 1..2^CNT_W-1
CNT_W, 8, persistence counter width
TS_W, 32, timestamp width
GID_W, 1, width of first_group; equals max(1, clog2(NUM_GROUPS))

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
axis_block_sigs  in  NUM_AXIS  per-channel AXIS blocked; group g owns bits [g*CH +: CH]
inst_idle_sigs  in  NUM_AXIS  per-channel idle indication, same grouping
inst_block_sigs  in  NUM_INST  sub-instance deadlock indications
group_enable  in  NUM_GROUPS  1 = group participates; 0 = group ignored
clear  in  1  synchronous clear of sticky and capture state
axis_block_info  out  NUM_AXIS  registered blocked-channel mask, gated by block
block  out  1  deadlock currently declared
block_sticky  out  1  deadlock was declared since the last reset or clear
first_group  out  GID_W  lowest blocked group index at the first declaration
first_ts  out  TS_W  timestamp of the first declaration

Behaviour:
- Reset (asynchronous, active-high): all outputs 0, FSM in IDLE, cnt=0, ts=0.
- grp_blk[g] = group_enable[g] & (|axis_block_sigs[g]) & ~(&inst_idle_sigs[g]). A group blocks when any channel is blocked and not every instance in it is idle.
- cand = (|grp_blk) | (|inst_block_sigs).
- ts: free-running counter, +1 every clock, saturates at all-ones and does not wrap; unaffected by clear.
- FSM states:
  - IDLE: cand=1 -> cnt<=1, then BLOCKED if THRESH==1, else PEND. cand=0 -> cnt stays 0.
  - PEND: cand=0 -> IDLE, cnt<=0. cand=1 -> cnt<=cnt+1; move to BLOCKED on the edge where cnt+1==THRESH.
  - BLOCKED: block=1. cand=0 -> IDLE, cnt<=0, block=0 on the next cycle. cnt holds at THRESH while in this state.
- Latency: if cand is sampled high on THRESH consecutive edges, block is high after the THRESH-th edge. A single low sample restarts the count.
- axis_block_info (registered each edge):
  - Bit i = axis_block_sigs[i] & group_enable[i/CH] when the next state is BLOCKED; 0 otherwise.
  - Consequently it goes to 0 on the same edge block drops.
- On entering BLOCKED with block_sticky=0:
  - block_sticky<=1, first_ts<=ts.
  - first_group<=lowest g with grp_blk[g]=1; 0 if only inst_block_sigs caused the entry.
- Later entries leave first_group and first_ts unchanged until clear.
- clear=1 (synchronous):
  - block_sticky, first_group, first_ts, cnt <= 0; FSM <= IDLE.
  - clear wins over a simultaneous entry into BLOCKED.
  - If cand is still 1, detection restarts from cnt=1 on the following edge.
- group_enable changes take effect in the same cycle's grp_blk; disabling the only blocked group drops cand, which resets cnt.
- Reset asserted mid-PEND or mid-BLOCKED returns everything to reset values immediately, with no clock needed.

Test Plan:
- Defaults; axis_block_sigs=4'b0001, inst_idle=0 held 16 edges -> block=1 after edge 16, axis_block_info=4'b0001, first_group=0, block_sticky=1.
- Same stimulus but dropped low at edge 10, then re-raised -> block stays 0; a fresh 16-edge window is required before block=1.
- axis_block_sigs=4'b1000, group_enable=2'b01 -> block never asserts; switching group_enable to 2'b11 -> block=1 16 edges later, first_group=1, axis_block_info=4'b1000.
- THRESH=1, inst_block_sigs=1 for one edge -> block=1 for one cycle, then 0 while block_sticky stays 1; first_group=0.
- After a deadlock, cand=0, pulse clear -> block_sticky=0, first_ts=0; next deadlock captures a new first_ts equal to ts at its entry edge.
- Assert reset while in BLOCKED without a clock edge -> block, block_sticky and axis_block_info go to 0 immediately; clear asserted on the entry edge -> block_sticky stays 0.

Source files
------------

// File: rtl/aesl_deadlock_group_monitor.sv
// Grouped deadlock monitor for the C/RTL co-sim bench: persistence-filtered
// block detection with sticky reporting, first-event capture and group masking.

module aesl_dgm_group #(
  parameter int CH = 2
) (
  input  logic [CH-1:0] axis_blk,
  input  logic [CH-1:0] idle,
  input  logic          en,
  output logic          grp_blk
);
  // A group is stuck when some channel is blocked while not every instance is idle.
  assign grp_blk = en & (|axis_blk) & ~(&idle);
endmodule

module aesl_deadlock_group_monitor #(
  parameter int NUM_AXIS   = 4,
  parameter int NUM_GROUPS = 2,
  parameter int NUM_INST   = 1,
  parameter int THRESH     = 16,
  parameter int CNT_W      = 8,
  parameter int TS_W       = 32,
  parameter int GID_W      = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_AXIS-1:0]   axis_block_sigs,
  input  logic [NUM_AXIS-1:0]   inst_idle_sigs,
  input  logic [NUM_INST-1:0]   inst_block_sigs,
  input  logic [NUM_GROUPS-1:0] group_enable,
  input  logic                  clear,
  output logic [NUM_AXIS-1:0]   axis_block_info,
  output logic                  block,
  output logic                  block_sticky,
  output logic [GID_W-1:0]      first_group,
  output logic [TS_W-1:0]       first_ts
);
  localparam int CH = NUM_AXIS / NUM_GROUPS;

  typedef enum logic [1:0] {IDLE, PEND, BLOCKED} state_t;

  state_t                          state, state_nxt;
  logic [CNT_W-1:0]                cnt, cnt_nxt;
  logic [TS_W-1:0]                 ts;
  logic [NUM_GROUPS-1:0][CH-1:0]   axis_g, idle_g;
  logic [NUM_GROUPS-1:0]           grp_blk;
  logic [NUM_AXIS-1:0]             en_mask;
  logic [GID_W-1:0]                low_grp;
  logic                            cand, enter;

  assign axis_g = axis_block_sigs;
  assign idle_g = inst_idle_sigs;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    aesl_dgm_group #(.CH(CH)) u_grp (
      .axis_blk (axis_g[g]),
      .idle     (idle_g[g]),
      .en       (group_enable[g]),
      .grp_blk  (grp_blk[g])
    );
    assign en_mask[g*CH +: CH] = {CH{group_enable[g]}};
  end

  assign cand = (|grp_blk) | (|inst_block_sigs);

  // Descending scan so the lowest blocked group wins.
  always_comb begin
    low_grp = '0;
    for (int g = NUM_GROUPS - 1; g >= 0; g--)
      if (grp_blk[g]) low_grp = GID_W'(g);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (cand) begin
        cnt_nxt   = CNT_W'(1);
        state_nxt = (THRESH == 1) ? BLOCKED : PEND;
      end
      PEND: if (!cand) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt_nxt == CNT_W'(THRESH)) state_nxt = BLOCKED;
      end
      BLOCKED: if (!cand) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Clear overrides any entry into BLOCKED on this edge.
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  assign enter = (state != BLOCKED) && (state_nxt == BLOCKED);
  assign block = (state == BLOCKED);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      ts              <= '0;
      axis_block_info <= '0;
      block_sticky    <= 1'b0;
      first_group     <= '0;
      first_ts        <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (ts != '1) ts <= ts + TS_W'(1);
      axis_block_info <= (state_nxt == BLOCKED) ? (axis_block_sigs & en_mask) : '0;
      if (clear) begin
        block_sticky <= 1'b0;
        first_group  <= '0;
        first_ts     <= '0;
      end else if (enter && !block_sticky) begin
        block_sticky <= 1'b1;
        first_group  <= low_grp;
        first_ts     <= ts;
      end
    end
  end
endmodule

// File: tb/tb_aesl_deadlock_group_monitor.sv
// Bench for aesl_deadlock_group_monitor: THRESH=16 and THRESH=1 instances on
// shared stimulus, checked against a run-length reference model.
`timescale 1ns/1ps
module tb_aesl_deadlock_group_monitor;
  localparam int NG = 2;
  localparam int CH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  axis_block_sigs = '0;
  logic [3:0]  inst_idle_sigs = '0;
  logic [0:0]  inst_block_sigs = '0;
  logic [1:0]  group_enable = 2'b11;
  logic        clear = 1'b0;

  logic [3:0]  info_a, info_b;
  logic        block_a, block_b, sticky_a, sticky_b;
  logic [0:0]  fg_a, fg_b;
  logic [31:0] fts_a, fts_b;

  always #5 clock = ~clock;

  aesl_deadlock_group_monitor #(.THRESH(16)) dut_a (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
    .group_enable(group_enable), .clear(clear), .axis_block_info(info_a),
    .block(block_a), .block_sticky(sticky_a), .first_group(fg_a), .first_ts(fts_a));

  aesl_deadlock_group_monitor #(.THRESH(1)) dut_b (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
    .group_enable(group_enable), .clear(clear), .axis_block_info(info_b),
    .block(block_b), .block_sticky(sticky_b), .first_group(fg_b), .first_ts(fts_b));

  // Reference model: a deadlock is declared while the run of consecutive
  // candidate samples has reached the threshold.
  int              thr [2] = '{16, 1};
  int              run [2];
  bit              m_blk [2], m_sticky [2];
  logic [0:0]      m_fg [2];
  logic [31:0]     m_fts [2];
  logic [3:0]      m_info [2];
  longint unsigned m_ts;
  int              checks = 0, fails = 0;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      run[i] = 0; m_blk[i] = 0; m_sticky[i] = 0;
      m_fg[i] = '0; m_fts[i] = '0; m_info[i] = '0;
    end
    m_ts = 0;
  endfunction

  function automatic int lowest_blocked_group();
    bit any_blk, all_idle;
    for (int g = 0; g < NG; g++) begin
      any_blk = 0; all_idle = 1;
      for (int c = 0; c < CH; c++) begin
        any_blk  = any_blk  | axis_block_sigs[g*CH + c];
        all_idle = all_idle & inst_idle_sigs[g*CH + c];
      end
      if (group_enable[g] && any_blk && !all_idle) return g;
    end
    return -1;
  endfunction

  function automatic void model_edge();
    int  lg;
    bit  cand, was;
    logic [3:0] en_exp;
    lg = lowest_blocked_group();
    cand = (lg >= 0) || (inst_block_sigs != 0);
    en_exp = {{2{group_enable[1]}}, {2{group_enable[0]}}};
    for (int i = 0; i < 2; i++) begin
      if (clear) begin
        run[i] = 0; m_blk[i] = 0; m_sticky[i] = 0;
        m_fg[i] = '0; m_fts[i] = '0; m_info[i] = '0;
      end else begin
        was = m_blk[i];
        run[i] = cand ? ((run[i] < 1000) ? run[i] + 1 : run[i]) : 0;
        m_blk[i] = (run[i] >= thr[i]);
        if (m_blk[i] && !was && !m_sticky[i]) begin
          m_sticky[i] = 1;
          m_fts[i] = m_ts[31:0];
          m_fg[i] = (lg > 0) ? 1'b1 : 1'b0;
        end
        m_info[i] = m_blk[i] ? (axis_block_sigs & en_exp) : 4'b0;
      end
    end
    if (m_ts < 64'hFFFF_FFFF) m_ts++;
  endfunction

  function automatic logic [38:0] obs(int i);
    return (i == 0) ? {block_a, sticky_a, fg_a, fts_a, info_a}
                    : {block_b, sticky_b, fg_b, fts_b, info_b};
  endfunction

  function automatic logic [38:0] expv(int i);
    return {m_blk[i], m_sticky[i], m_fg[i], m_fts[i], m_info[i]};
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({block_a, sticky_a, fg_a, fts_a, info_a, block_b, sticky_b, fg_b, fts_b, info_b} !== '0) begin
      fails++;
      $display("FAIL reset_state: got a=%h b=%h want all zero", obs(0), obs(1));
    end
    @(negedge clock); reset = 1'b0; model_reset();
  endtask

  task automatic test_basic();
    axis_block_sigs = 4'b0001; inst_idle_sigs = '0; group_enable = 2'b11;
    repeat (15) step();
    checks++;
    if (block_a !== 1'b0 || obs(0) !== expv(0)) begin
      fails++; $display("FAIL basic_pre15: got %h want %h", obs(0), expv(0));
    end
    step();
    checks++;
    if (block_a !== 1'b1 || info_a !== 4'b0001 || fg_a !== 1'b0 || sticky_a !== 1'b1 || fts_a !== 32'd15) begin
      fails++;
      $display("FAIL basic_entry: got blk=%b info=%b fg=%b sticky=%b ts=%0d want 1 0001 0 1 15",
               block_a, info_a, fg_a, sticky_a, fts_a);
    end
    checks++;
    if (block_b !== 1'b1 || sticky_b !== 1'b1 || fts_b !== 32'd0 || obs(1) !== expv(1)) begin
      fails++; $display("FAIL basic_thr1: got %h want %h", obs(1), expv(1));
    end
    axis_block_sigs = '0; step();
    checks++;
    if (block_a !== 1'b0 || info_a !== 4'b0 || sticky_a !== 1'b1) begin
      fails++; $display("FAIL basic_release: got blk=%b info=%b sticky=%b want 0 0000 1", block_a, info_a, sticky_a);
    end
  endtask

  task automatic test_drop();
    pulse_clear();
    axis_block_sigs = 4'b0001;
    repeat (9) step();
    axis_block_sigs = '0; step();
    axis_block_sigs = 4'b0001;
    repeat (15) step();
    checks++;
    if (block_a !== 1'b0 || obs(0) !== expv(0)) begin
      fails++; $display("FAIL drop_restart: got blk=%b (%h) want 0 (%h)", block_a, obs(0), expv(0));
    end
    step();
    checks++;
    if (block_a !== 1'b1 || obs(0) !== expv(0)) begin
      fails++; $display("FAIL drop_window: got blk=%b (%h) want 1 (%h)", block_a, obs(0), expv(0));
    end
    axis_block_sigs = '0; step();
  endtask

  task automatic test_enable();
    pulse_clear();
    axis_block_sigs = 4'b1000; group_enable = 2'b01;
    repeat (20) begin
      step();
      checks++;
      if (block_a !== 1'b0 || block_b !== 1'b0) begin
        fails++; $display("FAIL enable_masked: got a=%b b=%b want 0 0", block_a, block_b);
      end
    end
    group_enable = 2'b11;
    repeat (16) step();
    checks++;
    if (block_a !== 1'b1 || fg_a !== 1'b1 || info_a !== 4'b1000 || obs(0) !== expv(0)) begin
      fails++; $display("FAIL enable_entry: got blk=%b fg=%b info=%b want 1 1 1000", block_a, fg_a, info_a);
    end
    group_enable = 2'b01; step();
    checks++;
    if (block_a !== 1'b0 || info_a !== 4'b0 || obs(0) !== expv(0)) begin
      fails++; $display("FAIL enable_disable: got blk=%b info=%b want 0 0000", block_a, info_a);
    end
    axis_block_sigs = '0; group_enable = 2'b11; step();
  endtask

  task automatic test_thresh1();
    pulse_clear();
    inst_block_sigs = 1'b1; step();
    checks++;
    if (block_b !== 1'b1 || fg_b !== 1'b0 || sticky_b !== 1'b1 || block_a !== 1'b0) begin
      fails++; $display("FAIL thr1_entry: got b=%b fg=%b sticky=%b a=%b want 1 0 1 0", block_b, fg_b, sticky_b, block_a);
    end
    inst_block_sigs = 1'b0; step();
    checks++;
    if (block_b !== 1'b0 || sticky_b !== 1'b1 || obs(1) !== expv(1)) begin
      fails++; $display("FAIL thr1_release: got b=%b sticky=%b want 0 1", block_b, sticky_b);
    end
  endtask

  task automatic test_clear_ts();
    longint unsigned t0;
    pulse_clear();
    checks++;
    if (sticky_a !== 1'b0 || fts_a !== 32'd0 || fg_a !== 1'b0 || sticky_b !== 1'b0 || fts_b !== 32'd0) begin
      fails++; $display("FAIL clear_state: got sa=%b ta=%0d sb=%b tb=%0d want 0 0 0 0", sticky_a, fts_a, sticky_b, fts_b);
    end
    axis_block_sigs = 4'b0010;
    t0 = m_ts;
    step();
    checks++;
    if (fts_b !== 32'(t0) || sticky_b !== 1'b1) begin
      fails++; $display("FAIL clear_ts_b: got ts=%0d want %0d", fts_b, t0);
    end
    repeat (15) step();
    checks++;
    if (block_a !== 1'b1 || fts_a !== 32'(t0 + 15)) begin
      fails++; $display("FAIL clear_ts_a: got blk=%b ts=%0d want 1 %0d", block_a, fts_a, t0 + 15);
    end
    axis_block_sigs = '0; step();
  endtask

  task automatic test_reset_async();
    axis_block_sigs = 4'b0001;
    repeat (16) step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (block_a !== 1'b0 || sticky_a !== 1'b0 || info_a !== 4'b0 || fts_a !== 32'd0 ||
        block_b !== 1'b0 || sticky_b !== 1'b0 || info_b !== 4'b0) begin
      fails++; $display("FAIL async_reset: got a=%h b=%h want all zero", obs(0), obs(1));
    end
    model_reset();
    axis_block_sigs = '0;
    @(negedge clock); reset = 1'b0;
    inst_block_sigs = 1'b1; clear = 1'b1; step(); clear = 1'b0;
    checks++;
    if (block_b !== 1'b0 || sticky_b !== 1'b0) begin
      fails++; $display("FAIL clear_wins: got b=%b sticky=%b want 0 0", block_b, sticky_b);
    end
    step();
    checks++;
    if (block_b !== 1'b1 || sticky_b !== 1'b1 || obs(1) !== expv(1)) begin
      fails++; $display("FAIL clear_restart: got b=%b sticky=%b want 1 1", block_b, sticky_b);
    end
    inst_block_sigs = '0; step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(19) == 0) begin
        axis_block_sigs = 4'($urandom);
        inst_idle_sigs  = 4'($urandom);
        group_enable    = 2'($urandom);
      end
      inst_block_sigs = ($urandom_range(49) == 0) ? 1'b1 : 1'b0;
      clear = ($urandom_range(63) == 0) ? 1'b1 : 1'b0;
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) begin
          fails++; $display("FAIL random[%0d] cyc %0d: got %h want %h", i, n, obs(i), expv(i));
        end
      end
    end
    clear = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_drop();
    test_enable();
    test_thresh1();
    test_clear_ts();
    test_reset_async();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
